instr_loader_encoder: RTL and testbench
=======================================

// Module: instr_loader_encoder
// PURPOSE
//  Builds 32-bit ARM machine words from field-level requests and writes them sequentially into instruction memory.
//  It is the producer side of the Instr word that the single-cycle control unit decodes.
//  Used by self-test/boot logic to fill imem before the core is released.
// PARAMETERS
//  ADDR_W     6   imem word-address width
//  DEPTH      64  max words loaded before full; DEPTH <= 2**ADDR_W
//  BASE_ADDR  0   first imem word address written after reset/clear
// PORTS
//  clk          in   1       single clock, rising edge
//  reset        in   1       asynchronous, active-high
//  clear        in   1       sync: ptr->BASE_ADDR, count/err cleared
//  req_valid    in   1       request present
//  req_ready    out  1       request accepted when valid&&ready at clk edge
//  req_class    in   2       00 DP, 01 MEM, 10 BR, 11 illegal
//  req_cond     in   4       Instr[31:28]
//  req_cmd      in   4       DP cmd: ADD 0100, SUB 0010, AND 0000, ORR 1100, CMP 1010
//  req_i        in   1       DP: immediate Src2; MEM: 1 = immediate offset (encoded ~I=0)
//  req_s        in   1       DP set-flags
//  req_l        in   1       MEM: 1 LDR, 0 STR
//  req_rn       in   4       base/first operand register
//  req_rd       in   4       destination/source register
//  req_src2     in   12      DP Src2 / MEM imm12
//  req_imm24    in   24      BR offset, passed through
//  imem_we      out  1       write strobe
//  imem_addr    out  ADDR_W  write/readback address
//  imem_wdata   out  32      encoded word
//  imem_rdata   in   32      sync-read data (used only with LOADER_VERIFY_EN)
//  count        out  ADDR_W+1 words written since reset/clear
//  full         out  1       count==DEPTH
//  err          out  1       sticky: illegal request (or verify mismatch)
//  err_code     out  2       01 illegal class, 10 bad DP cmd, 11 verify mismatch; first error wins
// BEHAVIOUR
//  Reset: state IDLE, req_ready=0 during reset then 1; imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0, count=0, full=0, err=0, err_code=0.
//  FSM IDLE->WR->IDLE; req_ready = (state==IDLE)&&!full.
//  Accept edge: encoded word registered into imem_wdata, state->WR.
//  WR lasts 1 cycle: imem_we=1, imem_addr=BASE_ADDR+count. End of WR: count++, state->IDLE.
//  Throughput: 1 word per 2 cycles. Write strobe is registered-state driven; no combinational path req->imem_we.
//  Encoding:
//   DP  = {cond,2'b00,I,cmd,S,Rn,Rd,src2}.
//   CMP forces S=1, Rd=0.
//   MEM = {cond,2'b01,~I,P=1,U=1,B=0,W=0,L,Rn,Rd,imm12}.
//   BR  = {cond,2'b10,2'b10,imm24}.
//  Illegal class 11 or DP cmd outside the set: request is accepted (handshake completes) with no write and count unchanged.
//   Error sets err/err_code; state stays IDLE.
//  Full: when count reaches DEPTH, full=1 and req_ready=0 until clear or reset. Address never wraps.
//  clear: highest priority in all states; next state IDLE.
//   If asserted during WR, that cycle's write still occurs, but count is forced to 0 rather than incremented.
//  Reset mid-WR aborts; a partially-held word is discarded.
//  count width ADDR_W+1 so that DEPTH=2**ADDR_W is representable.
// CONFIGURATION
//  LOADER_VERIFY_EN defined:
//   WR->RD->CMP->IDLE; RD holds imem_addr with imem_we=0.
//   CMP compares imem_rdata to imem_wdata; mismatch sets err, err_code=11. count++ at end of CMP.
//   Throughput: 1 word per 4 cycles.
//  Undefined: RD/CMP states absent; imem_rdata ignored; code 11 never produced.
// STRUCTURE
//  Shared header arm_isa_defs.vh: op-class codes, DP cmd codes, cond codes, err_code values.
//  Sub-module arm_instr_encode (combinational): fields in -> word + legal/err_code out; reusable by bench as a golden model.
// TESTING
//  1. ADD R1,R2,#5 AL (class00,cond E,cmd0100,I1,S0) -> imem_wdata=E2821005, imem_we 1 cycle at addr 0, count=1.
//  2. SUBS R3,R4,R5 then CMP R0,#0 with req_s=0 -> E0543005 at addr 0, E3500000 at addr 1 (S forced, Rd=0).
//  3. LDR R2,[R0,#8] / STR same / B EQ imm24=2 -> E5902008, E5802008, 0A000002 at addrs 0..2.
//  4. Class 11, then cmd 1111 -> no imem_we, err=1, err_code=01 (held after 2nd), count=0.
//  5. DEPTH=4, hold req_valid -> 4 writes at addrs 0..3, full=1, req_ready=0. clear -> full=0, next write at addr 0.
//  6. clear during WR -> write occurs, count=0. With LOADER_VERIFY_EN, force imem_rdata mismatch -> err_code=11.

Source files
------------

// File: rtl/instr_loader_encoder_pkg.sv
// rtl/instr_loader_encoder_pkg.sv - ARM ISA field codes, error codes and loader FSM states
// Purpose: shared definitions for the instruction loader/encoder slice.
// Contents: op-class codes, DP command codes, condition codes, err_code values,
//           loader state enum, DP command legality helper.
package instr_loader_encoder_pkg;

    localparam logic [1:0] CLS_DP  = 2'b00;
    localparam logic [1:0] CLS_MEM = 2'b01;
    localparam logic [1:0] CLS_BR  = 2'b10;
    localparam logic [1:0] CLS_ILL = 2'b11;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_AL = 4'b1110;

    localparam logic [1:0] ERR_NONE   = 2'b00;
    localparam logic [1:0] ERR_CLASS  = 2'b01;
    localparam logic [1:0] ERR_CMD    = 2'b10;
    localparam logic [1:0] ERR_VERIFY = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WR   = 2'b01,
        ST_RD   = 2'b10,
        ST_CMP  = 2'b11
    } state_t;

    function automatic logic is_dp_cmd(input logic [3:0] cmd);
        return (cmd == CMD_AND) || (cmd == CMD_SUB) || (cmd == CMD_ADD) ||
               (cmd == CMD_CMP) || (cmd == CMD_ORR);
    endfunction

endpackage

// File: rtl/instr_loader_encoder_if.sv
// rtl/instr_loader_encoder_if.sv - field-level instruction request bus
// Purpose: valid/ready request channel carrying ARM instruction fields.
// Signals: req_valid/req_ready handshake; req_class, req_cond, req_cmd, req_i,
//          req_s, req_l, req_rn, req_rd, req_src2, req_imm24 fields.
// Modports: master = request producer, slave = loader.
interface instr_loader_encoder_if;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_class;
    logic [3:0]  req_cond;
    logic [3:0]  req_cmd;
    logic        req_i;
    logic        req_s;
    logic        req_l;
    logic [3:0]  req_rn;
    logic [3:0]  req_rd;
    logic [11:0] req_src2;
    logic [23:0] req_imm24;

    modport master (
        output req_valid, req_class, req_cond, req_cmd, req_i, req_s, req_l,
               req_rn, req_rd, req_src2, req_imm24,
        input  req_ready
    );

    modport slave (
        input  req_valid, req_class, req_cond, req_cmd, req_i, req_s, req_l,
               req_rn, req_rd, req_src2, req_imm24,
        output req_ready
    );
endinterface

// File: rtl/instr_loader_encoder_encode.sv
// rtl/instr_loader_encoder_encode.sv - combinational ARM DP/MEM/BR word encoder
// Purpose: turns request fields into a 32-bit machine word plus legality.
// Ports: i_class/i_cond/i_cmd/i_i/i_s/i_l/i_rn/i_rd/i_src2/i_imm24 fields in;
//        o_word encoded word, o_legal request legal, o_err_code error class.
module instr_loader_encoder_encode
    import instr_loader_encoder_pkg::*;
(
    input  logic [1:0]  i_class,
    input  logic [3:0]  i_cond,
    input  logic [3:0]  i_cmd,
    input  logic        i_i,
    input  logic        i_s,
    input  logic        i_l,
    input  logic [3:0]  i_rn,
    input  logic [3:0]  i_rd,
    input  logic [11:0] i_src2,
    input  logic [23:0] i_imm24,
    output logic [31:0] o_word,
    output logic        o_legal,
    output logic [1:0]  o_err_code
);

    logic       w_s;
    logic [3:0] w_rd;

    always_comb begin
        o_word     = 32'h0;
        o_legal    = 1'b1;
        o_err_code = ERR_NONE;
        w_s        = i_s;
        w_rd       = i_rd;
        case (i_class)
            CLS_DP: begin
                if (is_dp_cmd(i_cmd)) begin
                    // CMP only exists to set flags and has no destination.
                    if (i_cmd == CMD_CMP) begin
                        w_s  = 1'b1;
                        w_rd = 4'h0;
                    end
                    o_word = {i_cond, 2'b00, i_i, i_cmd, w_s, i_rn, w_rd, i_src2};
                end else begin
                    o_legal    = 1'b0;
                    o_err_code = ERR_CMD;
                end
            end
            // Offset-mode bit is inverted: immediate offsets encode as 0.
            // Pre-indexed, add, word, no writeback.
            CLS_MEM: o_word = {i_cond, 2'b01, ~i_i, 1'b1, 1'b1, 1'b0, 1'b0, i_l,
                               i_rn, i_rd, i_src2};
            CLS_BR:  o_word = {i_cond, 2'b10, 2'b10, i_imm24};
            default: begin
                o_legal    = 1'b0;
                o_err_code = ERR_CLASS;
            end
        endcase
    end

endmodule

// File: rtl/instr_loader_encoder.sv
// rtl/instr_loader_encoder.sv - encodes field requests and writes them sequentially into imem
// Purpose: boot/self-test producer that fills instruction memory one word per request.
// Ports: i_clk, i_reset (async active-high), i_clear (sync restart), i_req (request bus slave),
//        o_imem_we/o_imem_addr/o_imem_wdata write port, i_imem_rdata readback,
//        o_count words written, o_full, o_err sticky, o_err_code first error.
// Config: LOADER_VERIFY_EN adds RD/CMP readback states comparing imem_rdata to the written word.
module instr_loader_encoder
    import instr_loader_encoder_pkg::*;
#(
    parameter int ADDR_W    = 6,
    parameter int DEPTH     = 64,
    parameter int BASE_ADDR = 0
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_clear,
    instr_loader_encoder_if.slave i_req,
    output logic                o_imem_we,
    output logic [ADDR_W-1:0]   o_imem_addr,
    output logic [31:0]         o_imem_wdata,
    input  logic [31:0]         i_imem_rdata,
    output logic [ADDR_W:0]     o_count,
    output logic                o_full,
    output logic                o_err,
    output logic [1:0]          o_err_code
);

    state_t          r_state;
    state_t          w_next;
    logic [31:0]     r_wdata;
    logic [ADDR_W:0] r_count;
    logic            r_err;
    logic [1:0]      r_err_code;

    logic [31:0]     w_word;
    logic            w_legal;
    logic [1:0]      w_code;
    logic            w_accept;
    logic            w_full;
    logic            w_done;

    instr_loader_encoder_encode u_encode (
        .i_class    (i_req.req_class),
        .i_cond     (i_req.req_cond),
        .i_cmd      (i_req.req_cmd),
        .i_i        (i_req.req_i),
        .i_s        (i_req.req_s),
        .i_l        (i_req.req_l),
        .i_rn       (i_req.req_rn),
        .i_rd       (i_req.req_rd),
        .i_src2     (i_req.req_src2),
        .i_imm24    (i_req.req_imm24),
        .o_word     (w_word),
        .o_legal    (w_legal),
        .o_err_code (w_code)
    );

    assign w_full   = (r_count == (ADDR_W+1)'(DEPTH));
    assign w_accept = i_req.req_valid && i_req.req_ready;

`ifdef LOADER_VERIFY_EN
    assign w_done = (r_state == ST_CMP);
`else
    assign w_done = (r_state == ST_WR);
    logic w_unused_rdata;
    assign w_unused_rdata = ^i_imem_rdata;
`endif

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) r_state <= ST_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (i_clear) begin
            w_next = ST_IDLE;
        end else begin
            case (r_state)
                // Illegal requests complete the handshake but never leave IDLE.
                ST_IDLE: if (w_accept && w_legal) w_next = ST_WR;
`ifdef LOADER_VERIFY_EN
                ST_WR:   w_next = ST_RD;
                ST_RD:   w_next = ST_CMP;
`endif
                default: w_next = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        o_imem_we = (r_state == ST_WR);
        // Ready is withheld during clear so a request is never acknowledged and then dropped.
        i_req.req_ready = (r_state == ST_IDLE) && !w_full && !i_clear && !i_reset;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_wdata    <= 32'h0;
            r_count    <= '0;
            r_err      <= 1'b0;
            r_err_code <= ERR_NONE;
        end else if (i_clear) begin
            // A write in flight still lands; only the bookkeeping restarts.
            r_count    <= '0;
            r_err      <= 1'b0;
            r_err_code <= ERR_NONE;
        end else begin
            if (w_accept) begin
                if (w_legal) begin
                    r_wdata <= w_word;
                end else if (!r_err) begin
                    r_err      <= 1'b1;
                    r_err_code <= w_code;
                end
            end
`ifdef LOADER_VERIFY_EN
            if ((r_state == ST_CMP) && (i_imem_rdata != r_wdata) && !r_err) begin
                r_err      <= 1'b1;
                r_err_code <= ERR_VERIFY;
            end
`endif
            if (w_done) r_count <= r_count + (ADDR_W+1)'(1);
        end
    end

    assign o_imem_addr  = ADDR_W'(BASE_ADDR) + r_count[ADDR_W-1:0];
    assign o_imem_wdata = r_wdata;
    assign o_count      = r_count;
    assign o_full       = w_full;
    assign o_err        = r_err;
    assign o_err_code   = r_err_code;

endmodule

// File: tb/tb_instr_loader_encoder.sv
// tb/tb_instr_loader_encoder.sv - self-checking bench for instr_loader_encoder
module tb_instr_loader_encoder;

    localparam int ADDR_W = 2;
    localparam int DEPTH  = 4;
    localparam int BASE   = 0;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              clear = 1'b0;
    logic [31:0]       rdata = 32'h0;
    bit                corrupt = 1'b0;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic [ADDR_W:0]   count;
    logic              full;
    logic              err;
    logic [1:0]        err_code;

    instr_loader_encoder_if bus();

    instr_loader_encoder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_clear      (clear),
        .i_req        (bus),
        .o_imem_we    (we),
        .o_imem_addr  (addr),
        .o_imem_wdata (wdata),
        .i_imem_rdata (rdata),
        .o_count      (count),
        .o_full       (full),
        .o_err        (err),
        .o_err_code   (err_code)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // imem stand-in with synchronous read; corrupt flips bit 0 of the readback.
    logic [31:0] mem [4];
    always @(posedge clk) begin
        if (we) mem[addr] <= wdata;
        rdata <= mem[addr] ^ {31'h0, corrupt};
    end

    // Reference encoder built from the ARM field layout with plain arithmetic.
    function automatic void model_enc(input int unsigned cls, cond, cmd, i, s, l, rn, rd, src2, imm24,
                                      output bit ok, output logic [1:0] code, output logic [31:0] w);
        int unsigned ss, dd;
        ok = 1'b1; code = 2'd0; w = 32'h0; ss = s; dd = rd;
        if (cls == 3) begin
            ok = 1'b0; code = 2'd1;
        end else if (cls == 0) begin
            if (!(cmd inside {0, 2, 4, 10, 12})) begin
                ok = 1'b0; code = 2'd2;
            end else begin
                if (cmd == 10) begin ss = 1; dd = 0; end
                w = (cond * 32'h1000_0000) + (i * 32'h0200_0000) + (cmd * 32'h0020_0000) +
                    (ss * 32'h0010_0000) + (rn * 32'h0001_0000) + (dd * 32'h1000) + src2;
            end
        end else if (cls == 1) begin
            w = (cond * 32'h1000_0000) + 32'h0400_0000 + ((1 - i) * 32'h0200_0000) +
                32'h0180_0000 + (l * 32'h0010_0000) + (rn * 32'h0001_0000) + (rd * 32'h1000) + src2;
        end else begin
            w = (cond * 32'h1000_0000) + 32'h0A00_0000 + imm24;
        end
    endfunction

    // Transaction-level model: phase counts cycles left in the current write.
    int          m_phase = 0;
    int          m_count = 0;
    bit          m_err   = 1'b0;
    logic [1:0]  m_code  = 2'd0;
    logic [31:0] m_word  = 32'h0;
    bit          m_bad   = 1'b0;

    function automatic bit exp_ready();
        return !reset && (m_phase == 0) && (m_count < DEPTH) && !clear;
    endfunction

    always @(posedge clk) begin
        bit          ok;
        logic [1:0]  code;
        logic [31:0] w;
        if (reset) begin
            m_phase <= 0; m_count <= 0; m_err <= 1'b0; m_code <= 2'd0; m_word <= 32'h0;
        end else if (clear) begin
            m_phase <= 0; m_count <= 0; m_err <= 1'b0; m_code <= 2'd0;
        end else begin
            case (m_phase)
                0: if (bus.req_valid && exp_ready()) begin
                    model_enc(int'(bus.req_class), int'(bus.req_cond), int'(bus.req_cmd),
                              int'(bus.req_i), int'(bus.req_s), int'(bus.req_l),
                              int'(bus.req_rn), int'(bus.req_rd), int'(bus.req_src2),
                              int'(bus.req_imm24), ok, code, w);
                    if (ok) begin
                        m_word  <= w;
                        m_phase <= 1;
                    end else if (!m_err) begin
                        m_err  <= 1'b1;
                        m_code <= code;
                    end
                end
`ifdef LOADER_VERIFY_EN
                1: m_phase <= 2;
                2: begin m_bad <= corrupt; m_phase <= 3; end
                default: begin
                    m_phase <= 0;
                    m_count <= m_count + 1;
                    if (m_bad && !m_err) begin m_err <= 1'b1; m_code <= 2'd3; end
                end
`else
                default: begin m_phase <= 0; m_count <= m_count + 1; end
`endif
            endcase
        end
    end

    logic [31:0] obs_data[$];
    int          obs_addr[$];

    always @(negedge clk) begin
        check("ready", 32'(bus.req_ready), 32'(exp_ready()));
        check("we", 32'(we), 32'(!reset && (m_phase == 1)));
        if (we) begin
            check("addr", 32'(addr), 32'((BASE + m_count) % (2 ** ADDR_W)));
            check("wdata", wdata, m_word);
            obs_data.push_back(wdata);
            obs_addr.push_back(int'(addr));
        end
        check("count", 32'(count), 32'(m_count));
        check("full", 32'(full), 32'(m_count == DEPTH));
        check("err", 32'(err), 32'(m_err));
        check("err_code", 32'(err_code), 32'(m_code));
    end

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #2; end
    endtask

    task automatic set_req(input logic [1:0] cls, input logic [3:0] cond, input logic [3:0] cmd,
                           input logic i, input logic s, input logic l, input logic [3:0] rn,
                           input logic [3:0] rd, input logic [11:0] src2, input logic [23:0] imm24);
        bus.req_class = cls; bus.req_cond = cond; bus.req_cmd = cmd; bus.req_i = i;
        bus.req_s = s; bus.req_l = l; bus.req_rn = rn; bus.req_rd = rd;
        bus.req_src2 = src2; bus.req_imm24 = imm24;
    endtask

    task automatic send();
        bus.req_valid = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.req_ready) begin
                @(posedge clk); #2;
                bus.req_valid = 1'b0;
                return;
            end
            @(posedge clk); #2;
        end
        n_checks++; n_fail++;
        $display("FAIL send_timeout: got no ready expected ready within 20 cycles");
        bus.req_valid = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step(1);
        clear = 1'b0;
        obs_data.delete();
        obs_addr.delete();
    endtask

    initial begin
        bus.req_valid = 1'b0;
        set_req(2'd0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 12'h0, 24'h0);
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        check("rst_we", 32'(we), 32'd0);
        check("rst_addr", 32'(addr), 32'd0);
        check("rst_wdata", wdata, 32'h0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_full", 32'(full), 32'd0);
        check("rst_err", 32'({err, err_code}), 32'd0);
        check("rst_ready", 32'(bus.req_ready), 32'd1);
        step(1);

        // ADD R1,R2,#5
        set_req(2'd0, 4'hE, 4'b0100, 1'b1, 1'b0, 1'b0, 4'd2, 4'd1, 12'd5, 24'h0);
        send(); step(4);
        check("t1_nwr", 32'(obs_data.size()), 32'd1);
        if (obs_data.size() >= 1) begin
            check("t1_word", obs_data[0], 32'hE282_1005);
            check("t1_addr", 32'(obs_addr[0]), 32'd0);
        end
        check("t1_count", 32'(count), 32'd1);
        do_clear();

        // SUBS R3,R4,R5 then CMP R0,#0 with S=0, Rd=7
        set_req(2'd0, 4'hE, 4'b0010, 1'b0, 1'b1, 1'b0, 4'd4, 4'd3, 12'd5, 24'h0);
        send(); step(4);
        set_req(2'd0, 4'hE, 4'b1010, 1'b1, 1'b0, 1'b0, 4'd0, 4'd7, 12'd0, 24'h0);
        send(); step(4);
        check("t2_nwr", 32'(obs_data.size()), 32'd2);
        if (obs_data.size() >= 2) begin
            check("t2_subs", obs_data[0], 32'hE054_3005);
            check("t2_cmp", obs_data[1], 32'hE350_0000);
            check("t2_addr1", 32'(obs_addr[1]), 32'd1);
        end
        do_clear();

        // LDR R2,[R0,#8] / STR R2,[R0,#8] / BEQ +2
        set_req(2'd1, 4'hE, 4'h0, 1'b1, 1'b0, 1'b1, 4'd0, 4'd2, 12'd8, 24'h0);
        send(); step(4);
        set_req(2'd1, 4'hE, 4'h0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd2, 12'd8, 24'h0);
        send(); step(4);
        set_req(2'd2, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 12'd0, 24'd2);
        send(); step(4);
        check("t3_nwr", 32'(obs_data.size()), 32'd3);
        if (obs_data.size() >= 3) begin
            check("t3_ldr", obs_data[0], 32'hE590_2008);
            check("t3_str", obs_data[1], 32'hE580_2008);
            check("t3_b", obs_data[2], 32'h0A00_0002);
            check("t3_addr2", 32'(obs_addr[2]), 32'd2);
        end
        check("t3_count", 32'(count), 32'd3);
        do_clear();

        // Illegal class, then undefined DP command: first error code is kept
        set_req(2'd3, 4'hE, 4'h4, 1'b0, 1'b0, 1'b0, 4'd1, 4'd1, 12'd1, 24'h0);
        send(); step(3);
        set_req(2'd0, 4'hE, 4'hF, 1'b0, 1'b0, 1'b0, 4'd1, 4'd1, 12'd1, 24'h0);
        send(); step(3);
        check("t4_nwr", 32'(obs_data.size()), 32'd0);
        check("t4_err", 32'(err), 32'd1);
        check("t4_code", 32'(err_code), 32'd1);
        check("t4_count", 32'(count), 32'd0);
        do_clear();
        check("t4_clr_err", 32'({err, err_code}), 32'd0);

        // Hold valid until full
        set_req(2'd0, 4'hE, 4'b1100, 1'b1, 1'b0, 1'b0, 4'd5, 4'd6, 12'h0A5, 24'h0);
        bus.req_valid = 1'b1;
        for (int k = 0; k < 40 && obs_data.size() < DEPTH; k++) step(1);
        step(6);
        @(negedge clk);
        check("t5_ready", 32'(bus.req_ready), 32'd0);
        check("t5_full", 32'(full), 32'd1);
        check("t5_count", 32'(count), 32'(DEPTH));
        check("t5_nwr", 32'(obs_data.size()), 32'(DEPTH));
        for (int k = 0; k < DEPTH && k < obs_addr.size(); k++)
            check("t5_addr", 32'(obs_addr[k]), 32'(k));
        step(1);
        bus.req_valid = 1'b0;
        do_clear();
        check("t5_clr_full", 32'(full), 32'd0);
        send(); step(4);
        check("t5_after_nwr", 32'(obs_data.size()), 32'd1);
        if (obs_addr.size() >= 1) check("t5_after_addr", 32'(obs_addr[0]), 32'd0);
        do_clear();

        // Clear while the write strobe is high
        set_req(2'd0, 4'hE, 4'b0000, 1'b0, 1'b1, 1'b0, 4'd8, 4'd9, 12'h00A, 24'h0);
        send();
        clear = 1'b1;
        step(1);
        clear = 1'b0;
        step(4);
        check("t6_nwr", 32'(obs_data.size()), 32'd1);
        if (obs_data.size() >= 1) check("t6_word", obs_data[0], 32'hE018_900A);
        check("t6_count", 32'(count), 32'd0);
        do_clear();

`ifdef LOADER_VERIFY_EN
        corrupt = 1'b1;
        set_req(2'd2, 4'hE, 4'h0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 12'd0, 24'h123456);
        send(); step(5);
        corrupt = 1'b0;
        check("t6v_err", 32'(err), 32'd1);
        check("t6v_code", 32'(err_code), 32'd3);
        check("t6v_count", 32'(count), 32'd1);
        do_clear();
`endif

        step(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
